audio_sample_feeder: RTL
========================

# audio_sample_feeder

Sample buffer and volume register that sits directly upstream of the PWM audio output stage. Accepts 8-bit unsigned audio samples over a valid/ready write port into a small FIFO and releases exactly one sample per PWM frame on DUTY. The PWM stage latches DUTY×VOL at the end of each frame. Also owns the 4-bit volume setting, stepped by single-cycle up/down pulses.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries (16).
- FRAME_BITS, 12: frame counter width; one frame = 2^FRAME_BITS clocks (4096), matching the PWM stage's counter.
- VOL_RESET, 8: VOL value after reset (0..15).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- WR_DATA  in  8  sample to enqueue, unsigned, 0x80 = silence.
- WR_VALID  in  1  WR_DATA valid this cycle.
- WR_READY  out  1  FIFO can accept a sample this cycle.
- VOL_UP  in  1  single-cycle pulse: volume +1.
- VOL_DN  in  1  single-cycle pulse: volume −1.
- DUTY  out  8  current sample to the PWM stage, registered.
- VOL  out  4  current volume to the PWM stage, registered.
- FRAME_TICK  out  1  one-cycle pulse, high in the cycle DUTY first shows a newly popped or underrun value.
- UNDERRUN  out  1  one-cycle pulse coincident with FRAME_TICK when the FIFO was empty at pop time.
- LEVEL  out  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2.

## Operation
- Reset values: DUTY=0x80, VOL=VOL_RESET, LEVEL=0, FRAME_TICK=0, UNDERRUN=0, frame counter=0, FIFO pointers=0. WR_READY forced 0 while RST_N low.
- Write: sample enqueued on a rising edge where WR_VALID && WR_READY. WR_READY = (LEVEL != 2^DEPTH_LOG2), from registered state only; no combinational path from WR_VALID.
- Frame counter: free-running FRAME_BITS-bit, wraps all-ones -> 0, never stalls.
- Pop: at the edge where counter == all-ones minus 1 (0xFFE), a pop is attempted:
  - LEVEL>0: head entry -> DUTY, LEVEL decrements.
  - LEVEL==0: underrun; DUTY per Configuration; UNDERRUN pulses.
  - FRAME_TICK pulses in the following cycle (counter == 0xFFF).
- Simultaneous write and pop, LEVEL>0 and not full: both happen, LEVEL unchanged.
- Write while full: not accepted (WR_READY=0). Pop in the same cycle frees a slot; WR_READY goes 1 the next cycle.
- Write at the pop edge while empty: treated as underrun; the written sample is stored (LEVEL becomes 1) and consumed at the next frame. No bypass.
- Pointers wrap modulo 2^DEPTH_LOG2. Full vs. empty is distinguished by LEVEL, not by pointer equality.
- Volume:
  - VOL_UP alone: VOL+1, saturates at 15.
  - VOL_DN alone: VOL−1, saturates at 0.
  - Both high together: no change.
  - Takes effect next cycle; the PWM stage applies it at its next frame latch.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). FIFO contents are discarded.

## Timing
- Counter alignment: frame counter and PWM counter both start at 0 out of reset.
- PWM latch: DUTY changes on the 0xFFE edge and is stable through the 0xFFF edge, where the PWM stage latches it. Each sample plays for exactly one full PWM frame.
- Write-to-first-play latency: depends on frame phase and LEVEL; at most (LEVEL+1)×2^FRAME_BITS clocks.
- Write throughput: one sample per cycle until full.
- DUTY, VOL, FRAME_TICK, UNDERRUN, LEVEL: all registered outputs.

## Configuration
- AUDIO_FEEDER_HOLD_LAST_EN defined: on underrun, DUTY keeps its previous value (last sample held).
- Not defined: on underrun, DUTY is set to 0x80 (mid-scale silence).
- All other behaviour is identical in both builds, including the UNDERRUN pulse.

## Test plan
- Reset and idle: release RST_N with no writes -> DUTY=0x80, VOL=8, LEVEL=0. First FRAME_TICK at cycle 4095 after release, with UNDERRUN=1 and DUTY unchanged (0x80) in both builds.
- Ordered playback: write 0x10, 0x20, 0x30 back-to-back at cycle 10 -> LEVEL=3. DUTY=0x10 from cycle 4095, 0x20 from 8191, 0x30 from 12287. UNDERRUN=0 at those three ticks and 1 at the fourth.
- Full FIFO: hold WR_VALID high with 17 distinct bytes -> 16 accepted, WR_READY=0 while LEVEL=16. After the 0xFFE pop, WR_READY returns to 1 the next cycle and the 17th byte is accepted. Readback order matches write order.
- Underrun modes: write 0x55, let it play, no further writes -> at the next tick UNDERRUN=1. DUTY=0x55 with AUDIO_FEEDER_HOLD_LAST_EN defined, 0x80 without.
- Volume saturation: 10 VOL_UP pulses from 8 -> VOL=15. Then 20 VOL_DN pulses -> VOL=0. VOL_UP and VOL_DN in the same cycle -> VOL unchanged.
- Mid-frame reset and write at pop edge: with LEVEL=5 at counter 0x800, pulse RST_N low -> immediately LEVEL=0, DUTY=0x80, VOL=8. Separately, with the FIFO empty, write 0x33 at the 0xFFE edge -> UNDERRUN=1, LEVEL=1, DUTY=0x33 one frame later.

Source files
------------

// File: rtl/audio_sample_feeder_if.sv
// Sample write port of audio_sample_feeder: 8-bit unsigned samples, 0x80 = silence.
// A sample transfers on every rising clock edge where WR_VALID && WR_READY; WR_VALID may
// assert at any time, WR_READY never depends on WR_VALID, and an unaccepted sample must be held.
interface audio_sample_feeder_if;
    logic [7:0] WR_DATA;
    logic       WR_VALID;
    logic       WR_READY;

    modport master (output WR_DATA, output WR_VALID, input WR_READY);
    modport slave  (input WR_DATA, input WR_VALID, output WR_READY);
endinterface

// File: rtl/audio_sample_feeder.sv
// Sample FIFO plus volume register feeding the PWM audio stage; one sample is released per frame.
// AUDIO_FEEDER_HOLD_LAST_EN: on underrun, hold the last DUTY instead of returning to 0x80.
module audio_sample_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int FRAME_BITS = 12,
    parameter int VOL_RESET  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    audio_sample_feeder_if.slave wr,
    input  logic                 VOL_UP,
    input  logic                 VOL_DN,
    output logic [7:0]           DUTY,
    output logic [3:0]           VOL,
    output logic                 FRAME_TICK,
    output logic                 UNDERRUN,
    output logic [DEPTH_LOG2:0]  LEVEL
);
    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [FRAME_BITS-1:0] FRAME_ONE  = FRAME_BITS'(1);
    // Pop one edge before the frame wraps so DUTY is stable when the PWM latches at all-ones.
    localparam logic [FRAME_BITS-1:0] POP_PHASE  = {{(FRAME_BITS - 1){1'b1}}, 1'b0};
    localparam logic [7:0]            SILENCE    = 8'h80;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [FRAME_BITS-1:0] frame_cnt;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop_edge;
    logic                  pop_ok;
    logic [DEPTH_LOG2:0]   level_next;
    logic [7:0]            duty_next;
    logic [3:0]            vol_next;

    assign fifo_empty  = (LEVEL == '0);
    assign wr.WR_READY = RST_N && (LEVEL != FULL_LEVEL);
    assign push        = wr.WR_VALID && wr.WR_READY;
    assign pop_edge    = (frame_cnt == POP_PHASE);
    assign pop_ok      = pop_edge && !fifo_empty;

    always_comb begin
        level_next = LEVEL;
        if (push && !pop_ok) begin
            level_next = LEVEL + LEVEL_ONE;
        end else if (pop_ok && !push) begin
            level_next = LEVEL - LEVEL_ONE;
        end
    end

    always_comb begin
        duty_next = DUTY;
        if (pop_ok) begin
            duty_next = mem[rd_ptr];
        end else if (pop_edge) begin
`ifdef AUDIO_FEEDER_HOLD_LAST_EN
            duty_next = DUTY;
`else
            duty_next = SILENCE;
`endif
        end
    end

    // Opposing pulses in the same cycle cancel; both directions saturate.
    always_comb begin
        vol_next = VOL;
        if (VOL_UP && !VOL_DN && (VOL != 4'hF)) begin
            vol_next = VOL + 4'd1;
        end else if (VOL_DN && !VOL_UP && (VOL != 4'h0)) begin
            vol_next = VOL - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            LEVEL      <= '0;
            DUTY       <= SILENCE;
            VOL        <= 4'(VOL_RESET);
            FRAME_TICK <= 1'b0;
            UNDERRUN   <= 1'b0;
        end else begin
            frame_cnt  <= frame_cnt + FRAME_ONE;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            LEVEL      <= level_next;
            DUTY       <= duty_next;
            VOL        <= vol_next;
            FRAME_TICK <= pop_edge;
            UNDERRUN   <= pop_edge && fifo_empty;
        end
    end

    // Storage needs no reset: LEVEL and the pointers decide what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr.WR_DATA;
        end
    end
endmodule
